// File: rtl/orb_moment_accum.sv
// Streaming ORB intensity-centroid accumulator: m10/m01 over a circular patch mask.
// Define ORB_MOMENT_ROUND_EN to round half-up before the output shift.
module orb_moment_accum #(
  parameter int PIX_W     = 8,
  parameter int RADIUS    = 18,
  parameter int ACC_W     = 22,
  parameter int BIT_WIDTH = 12,
  parameter int SHIFT     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 pix_valid,
  input  logic                 pix_sop,
  input  logic [PIX_W-1:0]     pix,
  output logic                 pix_ready,
  output logic                 out_valid,
  output logic [BIT_WIDTH-1:0] m10_abs,
  output logic [BIT_WIDTH-1:0] m01_abs,
  output logic                 m10_neg,
  output logic                 m01_neg
);

  localparam int SIDE = 2 * RADIUS + 1;
  localparam int CW   = $clog2(SIDE);
  localparam int XW   = CW + 1;
  localparam int PW   = XW + PIX_W + 1;

  localparam logic [CW-1:0] RC   = CW'(RADIUS);
  localparam logic [CW-1:0] LAST = CW'(2 * RADIUS);
  localparam logic [ACC_W:0] SAT = (ACC_W + 1)'((1 << BIT_WIDTH) - 1);
`ifdef ORB_MOMENT_ROUND_EN
  localparam logic [ACC_W:0] RND =
    (SHIFT > 0) ? ((ACC_W + 1)'(1) << (SHIFT > 0 ? SHIFT - 1 : 0)) : '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_FLUSH,
    S_OUT
  } state_t;

  function automatic int half_width(input int ay);
    int hw;
    hw = 0;
    for (int k = 0; k <= RADIUS; k++) begin
      if (k * k + ay * ay <= RADIUS * RADIUS) hw = k;
    end
    return hw;
  endfunction

  function automatic logic [BIT_WIDTH-1:0] scale(
    input logic signed [ACC_W-1:0] a
  );
    logic [ACC_W:0] m;
    m = {1'b0, a[ACC_W-1] ? -a : a};
`ifdef ORB_MOMENT_ROUND_EN
    m = m + RND;
`endif
    m = m >> SHIFT;
    return (m > SAT) ? SAT[BIT_WIDTH-1:0] : m[BIT_WIDTH-1:0];
  endfunction

  state_t r_state;
  state_t w_state_nx;

  logic [CW-1:0] r_col;
  logic [CW-1:0] r_row;

  logic                 r_s1_vld;
  logic                 r_s1_first;
  logic                 r_s1_last;
  logic signed [PW-1:0] r_s1_px;
  logic signed [PW-1:0] r_s1_py;

  logic signed [ACC_W-1:0] r_m10;
  logic signed [ACC_W-1:0] r_m01;

  logic                 r_ov;
  logic [BIT_WIDTH-1:0] r_a10;
  logic [BIT_WIDTH-1:0] r_a01;
  logic                 r_n10;
  logic                 r_n01;

  logic                 w_acc;
  logic                 w_take;
  logic                 w_last;
  logic [CW-1:0]        w_col;
  logic [CW-1:0]        w_row;
  logic [CW-1:0]        w_ax;
  logic [CW-1:0]        w_ay;
  logic                 w_in;
  logic signed [XW-1:0] w_x;
  logic signed [XW-1:0] w_y;
  logic signed [PW-1:0] w_xe;
  logic signed [PW-1:0] w_ye;
  logic signed [PW-1:0] w_pe;
  logic signed [PW-1:0] w_px;
  logic signed [PW-1:0] w_py;

  // Half-width of the circular mask for each |y|; rows past RADIUS never index it.
  logic [CW-1:0] w_hw [2**CW];
  for (genvar g = 0; g < 2**CW; g++) begin : g_hw
    localparam int HWV = half_width(g);
    assign w_hw[g] = HWV[CW-1:0];
  end

  assign pix_ready = ~rst & ((r_state == S_IDLE) | (r_state == S_ACCUM));
  assign w_acc     = pix_valid & pix_ready & ena;
  assign w_take    = w_acc & (pix_sop | (r_state == S_ACCUM));

  assign w_col  = pix_sop ? '0 : r_col;
  assign w_row  = pix_sop ? '0 : r_row;
  assign w_last = (r_state == S_ACCUM) & ~pix_sop &
                  (w_col == LAST) & (w_row == LAST);

  assign w_ax = (w_col >= RC) ? w_col - RC : RC - w_col;
  assign w_ay = (w_row >= RC) ? w_row - RC : RC - w_row;
  assign w_in = (w_ax <= w_hw[w_ay]);

  assign w_x  = $signed({1'b0, w_col}) - $signed({1'b0, RC});
  assign w_y  = $signed({1'b0, w_row}) - $signed({1'b0, RC});
  assign w_xe = PW'(w_x);
  assign w_ye = PW'(w_y);
  assign w_pe = $signed(PW'({1'b0, pix}));
  assign w_px = w_in ? w_xe * w_pe : '0;
  assign w_py = w_in ? w_ye * w_pe : '0;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_acc && pix_sop) w_state_nx = S_ACCUM;
      S_ACCUM: if (w_take && w_last) w_state_nx = S_FLUSH;
      S_FLUSH: if (r_s1_last) w_state_nx = S_OUT;
      S_OUT:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
    end else if (ena) begin
      r_state <= w_state_nx;
      if (w_take) begin
        if (w_col == LAST) begin
          r_col <= '0;
          r_row <= (w_row == LAST) ? '0 : w_row + 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_row <= w_row;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_px    <= '0;
      r_s1_py    <= '0;
    end else if (ena) begin
      r_s1_vld   <= w_take;
      r_s1_first <= w_take & pix_sop;
      r_s1_last  <= w_take & w_last;
      if (w_take) begin
        r_s1_px <= w_px;
        r_s1_py <= w_py;
      end
    end
  end

  // The sop pixel loads rather than adds, discarding any abandoned patch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m10 <= '0;
      r_m01 <= '0;
    end else if (ena && r_s1_vld) begin
      if (r_s1_first) begin
        r_m10 <= ACC_W'(r_s1_px);
        r_m01 <= ACC_W'(r_s1_py);
      end else begin
        r_m10 <= r_m10 + ACC_W'(r_s1_px);
        r_m01 <= r_m01 + ACC_W'(r_s1_py);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ov  <= 1'b0;
      r_a10 <= '0;
      r_a01 <= '0;
      r_n10 <= 1'b0;
      r_n01 <= 1'b0;
    end else if (ena) begin
      r_ov <= (r_state == S_OUT);
      if (r_state == S_OUT) begin
        r_a10 <= scale(r_m10);
        r_a01 <= scale(r_m01);
        r_n10 <= r_m10[ACC_W-1];
        r_n01 <= r_m01[ACC_W-1];
      end
    end
  end

  assign out_valid = r_ov;
  assign m10_abs   = r_a10;
  assign m01_abs   = r_a01;
  assign m10_neg   = r_n10;
  assign m01_neg   = r_n01;

endmodule

// File: tb/tb_orb_moment_accum.sv
// Scoreboard bench for orb_moment_accum at SHIFT=10 (default), 6 and 0.
// Expected moments come from a direct x*x+y*y<=R*R model of the patch.
module tb_orb_moment_accum;

  localparam int R    = 18;
  localparam int SIDE = 2 * R + 1;
  localparam int NPIX = SIDE * SIDE;
  localparam int NDUT = 3;

  typedef struct {
    int a10 [NDUT];
    int a01 [NDUT];
    int n10;
    int n01;
    int lat;
    int start;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic ena;
  logic pix_valid;
  logic pix_sop;
  logic [7:0] pix;

  logic        rdy [NDUT];
  logic        ov  [NDUT];
  logic [11:0] a10 [NDUT];
  logic [11:0] a01 [NDUT];
  logic        n10 [NDUT];
  logic        n01 [NDUT];

  int shv [NDUT] = '{10, 6, 0};
  int img [NPIX];
  exp_t q [$];

  int n_chk = 0;
  int n_fail = 0;
  int n_ov = 0;
  int cyc = 0;
  logic prev_ov = 1'b0;

  orb_moment_accum u_dut (
    .clk(clk), .rst(rst), .ena(ena),
    .pix_valid(pix_valid), .pix_sop(pix_sop), .pix(pix),
    .pix_ready(rdy[0]), .out_valid(ov[0]),
    .m10_abs(a10[0]), .m01_abs(a01[0]),
    .m10_neg(n10[0]), .m01_neg(n01[0])
  );

  orb_moment_accum #(.SHIFT(6)) u_s6 (
    .clk(clk), .rst(rst), .ena(ena),
    .pix_valid(pix_valid), .pix_sop(pix_sop), .pix(pix),
    .pix_ready(rdy[1]), .out_valid(ov[1]),
    .m10_abs(a10[1]), .m01_abs(a01[1]),
    .m10_neg(n10[1]), .m01_neg(n01[1])
  );

  orb_moment_accum #(.SHIFT(0)) u_s0 (
    .clk(clk), .rst(rst), .ena(ena),
    .pix_valid(pix_valid), .pix_sop(pix_sop), .pix(pix),
    .pix_ready(rdy[2]), .out_valid(ov[2]),
    .m10_abs(a10[2]), .m01_abs(a01[2]),
    .m10_neg(n10[2]), .m01_neg(n01[2])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int mdl_scale(input int v, input int sh);
    int m;
    m = (v < 0) ? -v : v;
`ifdef ORB_MOMENT_ROUND_EN
    if (sh > 0) m = m + (1 << (sh - 1));
`endif
    m = m >> sh;
    return (m > 4095) ? 4095 : m;
  endfunction

  task automatic model(output int s10, output int s01);
    int x, y;
    s10 = 0;
    s01 = 0;
    for (int r = 0; r < SIDE; r++) begin
      for (int c = 0; c < SIDE; c++) begin
        x = c - R;
        y = r - R;
        if (x * x + y * y <= R * R) begin
          s10 += x * img[r * SIDE + c];
          s01 += y * img[r * SIDE + c];
        end
      end
    end
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < NPIX; i++) img[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, 255));
  endtask

  task automatic send_pix(input int p, input bit sop);
    pix_valid = 1'b1;
    pix = p[7:0];
    pix_sop = sop;
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sop = 1'b0;
  endtask

  task automatic send_partial(input int n);
    for (int i = 0; i < n; i++) send_pix(img[i], i == 0);
  endtask

  task automatic send_patch(input int pause_at, input int pause_len,
                            input int flush_pause);
    exp_t e;
    int s10, s01, st;
    model(s10, s01);
    st = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (i == pause_at) begin
        ena = 1'b0;
        pix_valid = 1'b1;
        pix = img[i][7:0];
        pix_sop = (i == 0);
        repeat (pause_len) @(posedge clk);
        #1;
        ena = 1'b1;
      end
      send_pix(img[i], i == 0);
      if (i == 0) st = cyc;
    end
    for (int k = 0; k < NDUT; k++) begin
      e.a10[k] = mdl_scale(s10, shv[k]);
      e.a01[k] = mdl_scale(s01, shv[k]);
    end
    e.n10 = (s10 < 0) ? 1 : 0;
    e.n01 = (s01 < 0) ? 1 : 0;
    e.start = st;
    e.lat = NPIX + 1 + ((pause_at >= 0) ? pause_len : 0) + flush_pause;
    q.push_back(e);
    if (flush_pause > 0) begin
      ena = 1'b0;
      repeat (flush_pause) @(posedge clk);
      #1;
      ena = 1'b1;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ov[0] && !prev_ov) begin
      n_ov++;
      if (q.size() == 0) begin
        chk("ov_unexpected", 1, 0);
      end else begin
        e = q.pop_front();
        chk("latency", cyc - e.start, e.lat);
        for (int k = 0; k < NDUT; k++) begin
          chk($sformatf("ov_s%0d", shv[k]), int'(ov[k]), 1);
          chk($sformatf("m10_abs_s%0d", shv[k]), int'(a10[k]), e.a10[k]);
          chk($sformatf("m01_abs_s%0d", shv[k]), int'(a01[k]), e.a01[k]);
          chk($sformatf("m10_neg_s%0d", shv[k]), int'(n10[k]), e.n10);
          chk($sformatf("m01_neg_s%0d", shv[k]), int'(n01[k]), e.n01);
        end
      end
    end else if (ov[0] && prev_ov) begin
      chk("ov_width", 2, 1);
    end
    prev_ov = ov[0];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    pix_valid = 1'b0;
    pix_sop = 1'b0;
    pix = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(rdy[0]), 0);
    chk("rst_ov", int'(ov[0]), 0);
    chk("rst_m10", int'(a10[0]), 0);
    chk("rst_m01", int'(a01[0]), 0);
    chk("rst_neg", int'(n10[0]) + int'(n01[0]), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_ready", int'(rdy[0]), 1);

    fill(128);
    send_patch(-1, 0, 0);

    fill(0);
    img[18 * SIDE + 0] = 255;
    send_patch(-1, 0, 0);

    repeat (5) send_pix(255, 1'b0);
    fill(0);
    img[0] = 255;
    send_patch(-1, 0, 0);

    fill(0);
    img[36 * SIDE + 18] = 255;
    send_patch(-1, 0, 0);

    fill_rand();
    send_partial(300);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready", int'(rdy[0]), 0);
    chk("midrst_m01_s10", int'(a01[0]), 0);
    chk("midrst_m01_s0", int'(a01[2]), 0);
    chk("midrst_ov", int'(ov[0]), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_idle_ready", int'(rdy[0]), 1);

    fill(255);
    send_partial(500);
    fill(128);
    send_patch(-1, 0, 0);

    fill(0);
    img[18 * SIDE + 0] = 255;
    send_patch(600, 10, 2);

    fill_rand();
    send_patch(-1, 0, 0);

    repeat (10) @(posedge clk);
    #1;
    chk("sb_empty", q.size(), 0);
    chk("ov_count", n_ov, 7);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
